// File: rtl/pc_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_queue_if
//   Bundles the two handshakes of the fetch front end.
//   Instruction memory (valid/grant request, in-order response):
//     imem_req, imem_addr   : request from fetch unit
//     imem_gnt              : request accepted this cycle
//     imem_rvalid, imem_rdata : response word, in request order
//   Decode (valid/ready):
//     instr_valid, instr, instr_pc, instr_pc_plus_4 : queue head
//     instr_ready           : decode consumes the head
//   master = fetch unit side, slave = memory/decode environment side.
// ----------------------------------------------------------------------------
interface pc_fetch_queue_if #(
    parameter int unsigned Xlen = 32
);
    logic            imem_req;
    logic [Xlen-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [Xlen-1:0] imem_rdata;
    logic            instr_valid;
    logic [Xlen-1:0] instr;
    logic [Xlen-1:0] instr_pc;
    logic [Xlen-1:0] instr_pc_plus_4;
    logic            instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc, instr_pc_plus_4,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc, instr_pc_plus_4,
        output instr_ready
    );
endinterface

// File: rtl/pc_fetch_queue.sv
// ----------------------------------------------------------------------------
// pc_fetch_queue
//   PC / fetch front end: holds the fetch PC, issues in-order instruction
//   memory requests, buffers returned words with their PC in a Depth-entry
//   queue and presents them to decode. A redirect loads a new PC from one of
//   NumSrc flattened targets and flushes the queue; responses still in flight
//   at that moment are dropped as they return.
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        synchronous, active-high reset
//   redirect_i   load PC from src_addr_i[pc_source_i], flush
//   pc_source_i  redirect source index (out of range selects source 0)
//   src_addr_i   flattened targets, source i = bits [i*Xlen +: Xlen]
//   count_o      queue occupancy
//   bus_io       memory request/response and decode handshakes
// ----------------------------------------------------------------------------
module pc_fetch_queue #(
    parameter int unsigned     Xlen     = 32,
    parameter logic [Xlen-1:0] ResetVec = '0,
    parameter int unsigned     Depth    = 4,
    parameter int unsigned     NumSrc   = 5,
    parameter int unsigned     Inc      = 4,
    localparam int unsigned    SrcW     = (NumSrc > 1) ? $clog2(NumSrc) : 1,
    localparam int unsigned    CntW     = $clog2(Depth + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   redirect_i,
    input  logic [SrcW-1:0]        pc_source_i,
    input  logic [NumSrc*Xlen-1:0] src_addr_i,
    output logic [CntW-1:0]        count_o,
    pc_fetch_queue_if.master       bus_io
);

    localparam int unsigned     PtrW   = $clog2(Depth);
    localparam logic [Xlen-1:0] IncV   = Xlen'(Inc);
    localparam logic [CntW:0]   DepthV = (CntW + 1)'(Depth);

    logic [Xlen-1:0] fetch_pc_q, fetch_pc_d;
    logic [Xlen-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [Xlen-1:0] data_q [Depth];
    logic [Xlen-1:0] pc_q   [Depth];

    logic [Xlen-1:0] target;
    logic [CntW:0]   credits_used;
    logic            instr_valid;
    logic            grant;
    logic            rsp;
    logic            push;
    logic            pop;

    // Out-of-range source indices fall back to source 0.
    always_comb begin
        target = src_addr_i[Xlen-1:0];
        for (int unsigned i = 1; i < NumSrc; i++) begin
            if (32'(pc_source_i) == i) begin
                target = src_addr_i[i*Xlen +: Xlen];
            end
        end
    end

    // Queued entries plus in-flight requests never exceed Depth, so a
    // returning response always finds a free slot.
    assign credits_used       = {1'b0, count_q} + {1'b0, outstanding_q};
    assign bus_io.imem_req    = !rst_i && !redirect_i && (credits_used < DepthV);
    assign bus_io.imem_addr   = fetch_pc_q;

    assign instr_valid            = !rst_i && !redirect_i && (count_q != '0);
    assign bus_io.instr_valid     = instr_valid;
    assign bus_io.instr           = data_q[rd_ptr_q];
    assign bus_io.instr_pc        = pc_q[rd_ptr_q];
    assign bus_io.instr_pc_plus_4 = pc_q[rd_ptr_q] + IncV;
    assign count_o                = count_q;

    assign grant = bus_io.imem_req && bus_io.imem_gnt;
    // Responses with nothing outstanding are protocol errors and ignored.
    assign rsp   = bus_io.imem_rvalid && (outstanding_q != '0);
    assign push  = rsp && (drop_q == '0) && !redirect_i;
    assign pop   = instr_valid && bus_io.instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (grant) begin
            outstanding_d = outstanding_d + CntW'(1);
        end
        if (rsp) begin
            outstanding_d = outstanding_d - CntW'(1);
        end

        if (redirect_i) begin
            // No grant is possible here, so everything still outstanding
            // after this cycle belongs to the old stream and must be dropped.
            fetch_pc_d = target;
            resp_pc_d  = target;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_d     = outstanding_d;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + IncV;
            end
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - CntW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + IncV;
                wr_ptr_d  = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= ResetVec;
            resp_pc_q     <= ResetVec;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr_q] <= bus_io.imem_rdata;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule
